// File: rtl/ll_rd_req_scheduler_pkg.sv
// Shared user-side definitions for the read-request path: the request
// descriptor width and helpers to move between the packed bus form and
// the named descriptor fields.
package ll_rd_req_scheduler_pkg;

    localparam int REQ_BITS = 104;

    // Field order is MSB to LSB.
    typedef struct packed {
        logic [15:0] rsrvd_high;
        logic [3:0]  cache_mode;
        logic [47:0] vaddr;
        logic [27:0] len;
        logic        stream;
        logic        sync;
        logic        ctl;
        logic [3:0]  dest;
        logic        rsrvd;
    } rd_req_t;

    function automatic logic [REQ_BITS-1:0] rd_req_pack(input rd_req_t r);
        return r;
    endfunction

    function automatic rd_req_t rd_req_unpack(input logic [REQ_BITS-1:0] b);
        return rd_req_t'(b);
    endfunction

endpackage

// File: rtl/ll_rd_req_scheduler_rr_arbiter.sv
// Round-robin arbiter. The search starts at the pointer and wraps; the
// pointer moves past the winner only when the grant is actually taken.
module ll_rd_req_scheduler_rr_arbiter #(
    parameter int N    = 16,
    parameter int ID_W = (N > 1) ? $clog2(N) : 1
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [N-1:0]    req,
    input  logic            advance,
    output logic [N-1:0]    grant,
    output logic [ID_W-1:0] grant_id
);

    logic [ID_W-1:0] ptr;

    // First requester at or above the pointer, wrapping past N-1.
    always_comb begin
        logic [ID_W:0]   sum;
        logic [ID_W-1:0] idx;
        logic            found;
        grant    = '0;
        grant_id = '0;
        found    = 1'b0;
        for (int off = 0; off < N; off++) begin
            sum = {1'b0, ptr} + (ID_W+1)'(off);
            if (sum >= (ID_W+1)'(N)) sum = sum - (ID_W+1)'(N);
            idx = sum[ID_W-1:0];
            if (!found && req[idx]) begin
                found      = 1'b1;
                grant[idx] = 1'b1;
                grant_id   = idx;
            end
        end
    end

    // Pointer moves to one past the winner whenever a grant is consumed.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr <= '0;
        end else if (advance && (|req)) begin
            ptr <= (grant_id == ID_W'(N-1)) ? '0 : grant_id + 1'b1;
        end
    end

endmodule

// File: rtl/ll_rd_req_scheduler.sv
// Shares one read-request channel between N_REQ traversal engines, remembers
// the owner of every issued request in order, and steers returning data
// beats back to the owner of the oldest outstanding request.
//
// Handshake: a transfer happens on a cycle where valid && ready are both
// high at the rising clock edge; valid never waits on ready, and a holder
// of valid keeps its payload stable until the transfer happens.
module ll_rd_req_scheduler #(
    parameter int N_REQ          = 16,
    parameter int ID_BITS        = $clog2(N_REQ),
    parameter int REQ_BITS       = ll_rd_req_scheduler_pkg::REQ_BITS,
    parameter int TAG_DEPTH      = 64,
    parameter int MAX_OUT_PER_ID = 8
) (
    input  logic                         aclk,
    input  logic                         aresetn,
    input  logic [N_REQ-1:0]             s_req_valid,
    output logic [N_REQ-1:0]             s_req_ready,
    input  logic [N_REQ*REQ_BITS-1:0]    s_req_data,
    output logic                         m_req_valid,
    input  logic                         m_req_ready,
    output logic [REQ_BITS-1:0]          m_req_data,
    output logic [ID_BITS-1:0]           m_req_id,
    input  logic                         s_rsp_tvalid,
    input  logic                         s_rsp_tlast,
    output logic                         s_rsp_tready,
    output logic [N_REQ-1:0]             m_rsp_tvalid,
    input  logic [N_REQ-1:0]             m_rsp_tready,
    output logic [ID_BITS-1:0]           rsp_id,
    output logic [$clog2(TAG_DEPTH):0]   outstanding,
    output logic                         idle
);
    import ll_rd_req_scheduler_pkg::*;

    localparam int AW    = $clog2(TAG_DEPTH);
    localparam int PTR_W = AW + 1;
    localparam int CNT_W = $clog2(MAX_OUT_PER_ID + 1);

    logic [PTR_W-1:0]   wr_ptr, rd_ptr;
    logic [ID_BITS-1:0] tag_mem [TAG_DEPTH];
    logic [CNT_W-1:0]   cnt [N_REQ];
    logic [N_REQ-1:0]   eligible, grant;
    logic [ID_BITS-1:0] grant_id, head;
    logic               full, empty, slot_free, push, pop;

    assign outstanding = wr_ptr - rd_ptr;
    assign full        = (outstanding == PTR_W'(TAG_DEPTH));
    assign empty       = (outstanding == '0);
    assign head        = tag_mem[rd_ptr[AW-1:0]];
    assign rsp_id      = head;
    assign idle        = empty && !m_req_valid;

    // The output stage can take a new request when empty or draining now.
    assign slot_free = !m_req_valid || m_req_ready;
    assign push      = slot_free && (|eligible);
    assign pop       = s_rsp_tvalid && s_rsp_tready && s_rsp_tlast;

    // Limits are judged on registered counts; no same-cycle pop bypass.
    always_comb begin
        for (int i = 0; i < N_REQ; i++) begin
            eligible[i] = s_req_valid[i] && (cnt[i] < CNT_W'(MAX_OUT_PER_ID)) && !full;
        end
    end

    ll_rd_req_scheduler_rr_arbiter #(.N(N_REQ), .ID_W(ID_BITS)) u_arb (
        .clk      (aclk),
        .rst_n    (aresetn),
        .req      (eligible),
        .advance  (slot_free),
        .grant    (grant),
        .grant_id (grant_id)
    );

    assign s_req_ready = push ? grant : '0;

    // Response beats go only to the owner of the oldest request.
    always_comb begin
        m_rsp_tvalid = '0;
        s_rsp_tready = 1'b0;
        if (!empty) begin
            m_rsp_tvalid[head] = s_rsp_tvalid;
            s_rsp_tready       = m_rsp_tready[head];
        end
    end

    // Output register: loads on grant, holds while the shell stalls.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            m_req_valid <= 1'b0;
            m_req_data  <= '0;
            m_req_id    <= '0;
        end else if (push) begin
            m_req_valid <= 1'b1;
            m_req_data  <= s_req_data[int'(grant_id)*REQ_BITS +: REQ_BITS];
            m_req_id    <= grant_id;
        end else if (m_req_ready) begin
            m_req_valid <= 1'b0;
        end
    end

    // Tag FIFO pointers; the extra MSB separates full from empty.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

    // Tag storage needs no reset; only slots between the pointers are read.
    always_ff @(posedge aclk) begin
        if (push) tag_mem[wr_ptr[AW-1:0]] <= grant_id;
    end

    // Per-engine outstanding counts; push and pop on one ID cancel.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            for (int i = 0; i < N_REQ; i++) cnt[i] <= '0;
        end else begin
            for (int i = 0; i < N_REQ; i++) begin
                case ({push && grant[i], pop && (head == ID_BITS'(i))})
                    2'b10:   cnt[i] <= cnt[i] + 1'b1;
                    2'b01:   cnt[i] <= cnt[i] - 1'b1;
                    default: cnt[i] <= cnt[i];
                endcase
            end
        end
    end

endmodule

// File: tb/tb_ll_rd_req_scheduler.sv
// Bench for ll_rd_req_scheduler: a hand-computed vector table, directed
// corner sequences and randomized traffic, all checked every cycle against
// a queue-based model of the scheduling rules.
module tb_ll_rd_req_scheduler;
    import ll_rd_req_scheduler_pkg::*;

    localparam int N   = 16;
    localparam int RB  = 104;
    localparam int TD  = 64;
    localparam int MAX = 8;

    // ---------------- clock / reset ----------------
    logic aclk = 1'b0;
    logic aresetn;
    always #5 aclk = ~aclk;

    logic [N-1:0]    s_req_valid, s_req_ready;
    logic [N*RB-1:0] s_req_data;
    logic            m_req_valid, m_req_ready;
    logic [RB-1:0]   m_req_data;
    logic [3:0]      m_req_id;
    logic            s_rsp_tvalid, s_rsp_tlast, s_rsp_tready;
    logic [N-1:0]    m_rsp_tvalid, m_rsp_tready;
    logic [3:0]      rsp_id;
    logic [6:0]      outstanding;
    logic            idle;

    ll_rd_req_scheduler dut (
        .aclk(aclk), .aresetn(aresetn),
        .s_req_valid(s_req_valid), .s_req_ready(s_req_ready), .s_req_data(s_req_data),
        .m_req_valid(m_req_valid), .m_req_ready(m_req_ready),
        .m_req_data(m_req_data), .m_req_id(m_req_id),
        .s_rsp_tvalid(s_rsp_tvalid), .s_rsp_tlast(s_rsp_tlast), .s_rsp_tready(s_rsp_tready),
        .m_rsp_tvalid(m_rsp_tvalid), .m_rsp_tready(m_rsp_tready),
        .rsp_id(rsp_id), .outstanding(outstanding), .idle(idle)
    );

    // ---------------- scoreboard ----------------
    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            if (n_bad <= 50) $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
        end
    endtask

    // ---------------- reference model ----------------
    int            m_ptr;
    int            m_cnt [N];
    int            m_q [$];          // owner IDs of outstanding requests, oldest first
    bit            m_st_valid;
    logic [RB-1:0] m_st_data;
    int            m_st_id;

    // Snapshots of DUT outputs from the most recent cycle() call.
    logic [N-1:0]  snap_ready, snap_tvalid;
    logic          snap_valid, snap_tready;
    logic [3:0]    snap_id;
    logic [6:0]    snap_out;

    task automatic model_reset();
        m_ptr = 0;
        for (int i = 0; i < N; i++) m_cnt[i] = 0;
        m_q.delete();
        m_st_valid = 1'b0;
        m_st_data  = '0;
        m_st_id    = 0;
    endtask

    // ---------------- driver tasks ----------------
    task automatic rand_data();
        rd_req_t d;
        for (int i = 0; i < N; i++) begin
            d.rsrvd_high = 16'($urandom);
            d.cache_mode = 4'($urandom);
            d.vaddr      = {16'($urandom), 32'($urandom)};
            d.len        = 28'($urandom);
            d.stream     = 1'($urandom);
            d.sync       = 1'($urandom);
            d.ctl        = 1'($urandom);
            d.dest       = 4'(i);
            d.rsrvd      = 1'b0;
            s_req_data[i*RB +: RB] = rd_req_pack(d);
        end
    endtask

    // One clock: called just after a falling edge with inputs applied;
    // checks outputs before the rising edge, then advances the model.
    task automatic cycle();
        int            gk;
        int            idx;
        int            h;
        int            popped;
        logic [N-1:0]  er, etv;
        logic          etr;
        bit            do_pop;
        #2;
        gk = -1;
        if ((!m_st_valid || m_req_ready) && m_q.size() < TD) begin
            for (int off = 0; off < N; off++) begin
                idx = (m_ptr + off) % N;
                if (gk < 0 && s_req_valid[idx] && m_cnt[idx] < MAX) gk = idx;
            end
        end
        er = '0;
        if (gk >= 0) er[gk] = 1'b1;
        etv = '0;
        etr = 1'b0;
        if (m_q.size() > 0) begin
            h = m_q[0];
            etv[h] = s_rsp_tvalid;
            etr = m_rsp_tready[h];
            chk("rsp_id", 128'(rsp_id), 128'(h));
        end
        chk("s_req_ready", 128'(s_req_ready), 128'(er));
        chk("m_req_valid", 128'(m_req_valid), 128'(m_st_valid));
        if (m_st_valid) begin
            chk("m_req_data", 128'(m_req_data), 128'(m_st_data));
            chk("m_req_id", 128'(m_req_id), 128'(m_st_id));
        end
        chk("outstanding", 128'(outstanding), 128'(m_q.size()));
        chk("idle", 128'(idle), 128'(m_q.size() == 0 && !m_st_valid));
        chk("m_rsp_tvalid", 128'(m_rsp_tvalid), 128'(etv));
        chk("s_rsp_tready", 128'(s_rsp_tready), 128'(etr));
        snap_ready = s_req_ready; snap_tvalid = m_rsp_tvalid;
        snap_valid = m_req_valid; snap_tready = s_rsp_tready;
        snap_id = m_req_id; snap_out = outstanding;
        do_pop = (m_q.size() > 0) && s_rsp_tvalid && etr && s_rsp_tlast;
        @(posedge aclk);
        if (do_pop) begin
            popped = m_q.pop_front();
            m_cnt[popped]--;
        end
        if (gk >= 0) begin
            m_q.push_back(gk);
            m_cnt[gk]++;
            m_ptr      = (gk + 1) % N;
            m_st_valid = 1'b1;
            m_st_data  = s_req_data[gk*RB +: RB];
            m_st_id    = gk;
        end else if (m_req_ready) begin
            m_st_valid = 1'b0;
        end
        @(negedge aclk);
    endtask

    task automatic drain();
        int n;
        s_req_valid = '0; m_req_ready = 1'b1; m_rsp_tready = '1;
        s_rsp_tvalid = 1'b1; s_rsp_tlast = 1'b1;
        n = 0;
        while ((m_q.size() > 0 || m_st_valid) && n < 300) begin
            cycle();
            n++;
        end
        chk("drain_done", 128'(outstanding), 128'(0));
        s_rsp_tvalid = 1'b0; s_rsp_tlast = 1'b0;
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        logic [15:0] req;
        logic        tv;
        logic        tl;
        logic [15:0] e_ready;
        logic        e_valid;
        logic [3:0]  e_id;
        logic [6:0]  e_out;
        logic [15:0] e_tvalid;
    } vec_t;

    vec_t tbl [13];

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout, required completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [RB-1:0] hold_data;
        int            hold_id, grants, h;

        // Engines 3 and 9 take turns; each response is two beats.
        tbl[0]  = '{16'h0208, 1'b0, 1'b0, 16'h0008, 1'b0, 4'd0, 7'd0, 16'h0000};
        tbl[1]  = '{16'h0208, 1'b0, 1'b0, 16'h0200, 1'b1, 4'd3, 7'd1, 16'h0000};
        tbl[2]  = '{16'h0000, 1'b1, 1'b0, 16'h0000, 1'b1, 4'd9, 7'd2, 16'h0008};
        tbl[3]  = '{16'h0000, 1'b1, 1'b1, 16'h0000, 1'b0, 4'd0, 7'd2, 16'h0008};
        tbl[4]  = '{16'h0000, 1'b1, 1'b0, 16'h0000, 1'b0, 4'd0, 7'd1, 16'h0200};
        tbl[5]  = '{16'h0000, 1'b1, 1'b1, 16'h0000, 1'b0, 4'd0, 7'd1, 16'h0200};
        tbl[6]  = '{16'h0208, 1'b0, 1'b0, 16'h0008, 1'b0, 4'd0, 7'd0, 16'h0000};
        tbl[7]  = '{16'h0200, 1'b0, 1'b0, 16'h0200, 1'b1, 4'd3, 7'd1, 16'h0000};
        tbl[8]  = '{16'h0000, 1'b1, 1'b0, 16'h0000, 1'b1, 4'd9, 7'd2, 16'h0008};
        tbl[9]  = '{16'h0000, 1'b1, 1'b1, 16'h0000, 1'b0, 4'd0, 7'd2, 16'h0008};
        tbl[10] = '{16'h0000, 1'b1, 1'b0, 16'h0000, 1'b0, 4'd0, 7'd1, 16'h0200};
        tbl[11] = '{16'h0000, 1'b1, 1'b1, 16'h0000, 1'b0, 4'd0, 7'd1, 16'h0200};
        tbl[12] = '{16'h0000, 1'b0, 1'b0, 16'h0000, 1'b0, 4'd0, 7'd0, 16'h0000};

        // Reset state.
        aresetn = 1'b0;
        s_req_valid = '0; m_req_ready = 1'b1; m_rsp_tready = '1;
        s_rsp_tvalid = 1'b0; s_rsp_tlast = 1'b0;
        rand_data();
        model_reset();
        #3;
        chk("rst_m_req_valid", 128'(m_req_valid), 128'(0));
        chk("rst_s_req_ready", 128'(s_req_ready), 128'(0));
        chk("rst_outstanding", 128'(outstanding), 128'(0));
        chk("rst_idle", 128'(idle), 128'(1));
        chk("rst_m_req_data", 128'(m_req_data), 128'(0));
        chk("rst_m_req_id", 128'(m_req_id), 128'(0));
        chk("rst_s_rsp_tready", 128'(s_rsp_tready), 128'(0));
        @(negedge aclk);
        aresetn = 1'b1;

        // Table-driven routing sequence.
        for (int r = 0; r < 13; r++) begin
            s_req_valid = tbl[r].req; s_rsp_tvalid = tbl[r].tv; s_rsp_tlast = tbl[r].tl;
            cycle();
            chk($sformatf("tbl%0d_ready", r), 128'(snap_ready), 128'(tbl[r].e_ready));
            chk($sformatf("tbl%0d_valid", r), 128'(snap_valid), 128'(tbl[r].e_valid));
            if (tbl[r].e_valid) chk($sformatf("tbl%0d_id", r), 128'(snap_id), 128'(tbl[r].e_id));
            chk($sformatf("tbl%0d_out", r), 128'(snap_out), 128'(tbl[r].e_out));
            chk($sformatf("tbl%0d_tvalid", r), 128'(snap_tvalid), 128'(tbl[r].e_tvalid));
        end
        s_rsp_tvalid = 1'b0; s_rsp_tlast = 1'b0;

        // Reset mid-traffic with five requests outstanding.
        s_req_valid = 16'h10C6;
        for (int c = 0; c < 5; c++) cycle();
        s_req_valid = '0;
        chk("pre_rst_out", 128'(outstanding), 128'(5));
        #1 aresetn = 1'b0;
        #1;
        chk("midrst_outstanding", 128'(outstanding), 128'(0));
        chk("midrst_idle", 128'(idle), 128'(1));
        chk("midrst_m_req_valid", 128'(m_req_valid), 128'(0));
        model_reset();
        @(negedge aclk);
        aresetn = 1'b1;

        // All engines requesting: IDs 0..15 then 0, one per cycle.
        s_req_valid = '1;
        for (int c = 0; c < 18; c++) begin
            rand_data();
            cycle();
            if (c < 17) chk($sformatf("rr%0d_grant", c), 128'(snap_ready), 128'(1) << (c % 16));
            chk($sformatf("rr%0d_valid", c), 128'(snap_valid), 128'(c > 0));
            if (c > 0) chk($sformatf("rr%0d_id", c), 128'(snap_id), 128'((c - 1) % 16));
        end
        drain();

        // Per-engine cap: engine 5 alone gets exactly eight grants.
        s_req_valid = 16'h0020; grants = 0;
        for (int c = 0; c < 10; c++) begin
            cycle();
            if (snap_ready[5]) grants++;
        end
        chk("limit_grants", 128'(grants), 128'(8));
        s_rsp_tvalid = 1'b1; s_rsp_tlast = 1'b1;
        cycle();
        chk("limit_pop_cycle_ready", 128'(snap_ready), 128'(0));
        s_rsp_tvalid = 1'b0; s_rsp_tlast = 1'b0;
        cycle();
        chk("limit_after_pop_ready", 128'(snap_ready), 128'(16'h0020));
        chk("limit_after_pop_out", 128'(snap_out), 128'(7));
        drain();

        // Fill the tag FIFO to capacity across engines.
        s_req_valid = '1;
        for (int c = 0; c < 200 && m_q.size() < TD; c++) cycle();
        cycle();
        chk("full_no_grant", 128'(snap_ready), 128'(0));
        chk("full_out", 128'(snap_out), 128'(64));
        s_rsp_tvalid = 1'b1; s_rsp_tlast = 1'b1;
        cycle();
        chk("full_pop_no_grant", 128'(snap_ready), 128'(0));
        chk("full_pop_out", 128'(snap_out), 128'(64));
        s_rsp_tvalid = 1'b0; s_rsp_tlast = 1'b0;
        cycle();
        chk("full_regrant", 128'(|snap_ready), 128'(1));
        chk("full_63", 128'(snap_out), 128'(63));
        cycle();
        chk("full_64_again", 128'(snap_out), 128'(64));

        // Host stalled by the owning engine: nothing pops.
        h = m_q[0];
        s_req_valid = '0; s_rsp_tvalid = 1'b1; s_rsp_tlast = 1'b1;
        m_rsp_tready = '1; m_rsp_tready[h] = 1'b0;
        for (int c = 0; c < 10; c++) begin
            cycle();
            chk("stall_tready", 128'(snap_tready), 128'(0));
            chk("stall_tvalid", 128'(snap_tvalid), 128'(1) << h);
            chk("stall_out", 128'(snap_out), 128'(64));
        end
        drain();

        // Shell stall: issued descriptor must stay put while inputs churn.
        m_req_ready = 1'b0; s_req_valid = 16'h0804;
        cycle();
        hold_data = m_st_data; hold_id = m_st_id;
        for (int c = 0; c < 4; c++) begin
            rand_data();
            cycle();
            chk("hold_valid", 128'(snap_valid), 128'(1));
            chk("hold_id", 128'(snap_id), 128'(hold_id));
            chk("hold_data", 128'(m_req_data), 128'(hold_data));
            chk("hold_no_grant", 128'(snap_ready), 128'(0));
        end
        drain();

        // Randomized traffic: slow drain first to reach full, then mixed.
        for (int c = 0; c < 3000; c++) begin
            rand_data();
            s_req_valid  = 16'($urandom);
            m_req_ready  = ($urandom_range(0, 3) != 0);
            s_rsp_tvalid = (c < 1000) ? ($urandom_range(0, 5) == 0) : ($urandom_range(0, 1) == 0);
            s_rsp_tlast  = ($urandom_range(0, 2) == 0);
            m_rsp_tready = 16'($urandom) | 16'($urandom);
            cycle();
        end
        drain();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
